// File: rtl/sram_arbiter_if.sv
// sram_arbiter_if
//   Bundles the two requester ports (instruction fetch, data load/store)
//   and the single-port SRAM connection of the arbiter.
//   slave  : arbiter view (consumes requests and sram_odata, drives
//            grants, read responses and the SRAM controls).
//   master : the opposite view, for the core side / SRAM model.
//   Signals:
//     i_req/i_addr          instruction read request and word address
//     i_gnt/i_rvalid/i_rdata instruction grant and read response
//     d_req/d_we/d_be/d_addr/d_wdata  data request, write flag, byte
//                           enables, word address, write data
//     d_gnt/d_rvalid/d_rdata data grant and read response
//     sram_rd_en/sram_wr_en/sram_addr/sram_idata  SRAM controls
//     sram_odata            SRAM registered read data
interface sram_arbiter_if;
   logic        i_req;
   logic [15:0] i_addr;
   logic        i_gnt;
   logic        i_rvalid;
   logic [31:0] i_rdata;

   logic        d_req;
   logic        d_we;
   logic [3:0]  d_be;
   logic [15:0] d_addr;
   logic [31:0] d_wdata;
   logic        d_gnt;
   logic        d_rvalid;
   logic [31:0] d_rdata;

   logic        sram_rd_en;
   logic        sram_wr_en;
   logic [15:0] sram_addr;
   logic [31:0] sram_idata;
   logic [31:0] sram_odata;

   modport slave (
      input  i_req, i_addr,
      output i_gnt, i_rvalid, i_rdata,
      input  d_req, d_we, d_be, d_addr, d_wdata,
      output d_gnt, d_rvalid, d_rdata,
      output sram_rd_en, sram_wr_en, sram_addr, sram_idata,
      input  sram_odata
   );

   modport master (
      output i_req, i_addr,
      input  i_gnt, i_rvalid, i_rdata,
      output d_req, d_we, d_be, d_addr, d_wdata,
      input  d_gnt, d_rvalid, d_rdata,
      input  sram_rd_en, sram_wr_en, sram_addr, sram_idata,
      output sram_odata
   );
endinterface

// File: rtl/sram_arbiter.sv
// sram_arbiter
//   Shares one single-port 32-bit SRAM (1-cycle registered read) between
//   the instruction-fetch port (read only) and the data port (read/write
//   with byte enables). Ties are broken round-robin. Partial-word writes
//   become a read followed by a merged full-word write.
//   Ports:
//     clk  system clock, all state on the rising edge
//     rst  asynchronous, active-low reset
//     bus  sram_arbiter_if.slave: requester handshakes and SRAM controls
//   Grants and SRAM controls are combinational; rvalids are registered.
module sram_arbiter (
   input  logic           clk,
   input  logic           rst,
   sram_arbiter_if.slave  bus
);

   localparam int ADDR_W = 16;
   localparam int DATA_W = 32;
   localparam int BE_W   = DATA_W / 8;

   typedef enum logic {IDLE, RMW_WR} state_t;

   // Control state
   state_t              state;
   state_t              state_nxt;
   logic                last_d;      // 1 = data port was granted last
   logic                last_d_nxt;
   logic                vld_i_p1;
   logic                vld_d_p1;

   // Partial-write operands captured in the read half of the RMW
   logic [ADDR_W-1:0]   rmw_addr_p1;
   logic [BE_W-1:0]     rmw_be_p1;
   logic [DATA_W-1:0]   rmw_wdata_p1;

   // Combinational decisions
   logic                pick_d;
   logic                i_gnt_c;
   logic                d_gnt_c;
   logic                i_rd_c;
   logic                d_rd_c;
   logic                rmw_start_c;
   logic                rd_en_c;
   logic                wr_en_c;
   logic [ADDR_W-1:0]   addr_c;
   logic [DATA_W-1:0]   idata_c;

   // Per-byte merge: enabled bytes from the new data, others from memory.
   function automatic logic [DATA_W-1:0] merge_bytes(
      input logic [DATA_W-1:0] wdata,
      input logic [DATA_W-1:0] old,
      input logic [BE_W-1:0]   be
   );
      logic [DATA_W-1:0] m;
      m = old;
      for (int k = 0; k < BE_W; k++) begin
         if (be[k]) m[8*k +: 8] = wdata[8*k +: 8];
      end
      return m;
   endfunction

   always_comb begin
      state_nxt   = state;
      last_d_nxt  = last_d;
      pick_d      = 1'b0;
      i_gnt_c     = 1'b0;
      d_gnt_c     = 1'b0;
      i_rd_c      = 1'b0;
      d_rd_c      = 1'b0;
      rmw_start_c = 1'b0;
      rd_en_c     = 1'b0;
      wr_en_c     = 1'b0;
      addr_c      = '0;
      idata_c     = '0;

      // Everything stays quiet while reset is asserted, even though the
      // async clear has already put the FSM in IDLE.
      if (rst) begin
         if (state == RMW_WR) begin
            // Second half of a partial write: sram_odata holds the old word.
            wr_en_c   = 1'b1;
            addr_c    = rmw_addr_p1;
            idata_c   = merge_bytes(rmw_wdata_p1, bus.sram_odata, rmw_be_p1);
            d_gnt_c   = 1'b1;
            state_nxt = IDLE;
         end else begin
            // Data wins when alone, or on a tie if instruction went last.
            pick_d = bus.d_req && (!bus.i_req || !last_d);
            if (pick_d) begin
               last_d_nxt = 1'b1;
               if (!bus.d_we) begin
                  rd_en_c = 1'b1;
                  addr_c  = bus.d_addr;
                  d_gnt_c = 1'b1;
                  d_rd_c  = 1'b1;
               end else if (&bus.d_be) begin
                  wr_en_c = 1'b1;
                  addr_c  = bus.d_addr;
                  idata_c = bus.d_wdata;
                  d_gnt_c = 1'b1;
               end else if (bus.d_be == '0) begin
                  // Nothing to write: complete without touching the SRAM.
                  d_gnt_c = 1'b1;
               end else begin
                  rd_en_c     = 1'b1;
                  addr_c      = bus.d_addr;
                  rmw_start_c = 1'b1;
                  state_nxt   = RMW_WR;
               end
            end else if (bus.i_req) begin
               last_d_nxt = 1'b0;
               rd_en_c    = 1'b1;
               addr_c     = bus.i_addr;
               i_gnt_c    = 1'b1;
               i_rd_c     = 1'b1;
            end
         end
      end
   end

   // Stage p0 -> p1: FSM, round-robin pointer and read-valid pipeline
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         last_d   <= 1'b0;
         vld_i_p1 <= 1'b0;
         vld_d_p1 <= 1'b0;
      end else begin
         state    <= state_nxt;
         last_d   <= last_d_nxt;
         vld_i_p1 <= i_rd_c;
         vld_d_p1 <= d_rd_c;
      end
   end

   // Stage p0 -> p1: partial-write operands (data only, no reset)
   always_ff @(posedge clk) begin
      if (rmw_start_c) begin
         rmw_addr_p1  <= bus.d_addr;
         rmw_be_p1    <= bus.d_be;
         rmw_wdata_p1 <= bus.d_wdata;
      end
   end

   assign bus.i_gnt      = i_gnt_c;
   assign bus.d_gnt      = d_gnt_c;
   assign bus.i_rvalid   = vld_i_p1;
   assign bus.d_rvalid   = vld_d_p1;
   assign bus.i_rdata    = bus.sram_odata;
   assign bus.d_rdata    = bus.sram_odata;
   assign bus.sram_rd_en = rd_en_c;
   assign bus.sram_wr_en = wr_en_c;
   assign bus.sram_addr  = addr_c;
   assign bus.sram_idata = idata_c;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter
//   Directed bench for sram_arbiter with a behavioural single-port SRAM
//   (16384 x 32, registered read) and a preload port for initial contents.
module tb_sram_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   sram_arbiter_if bus ();

   sram_arbiter dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   // Behavioural SRAM
   logic [31:0] mem [0:16383];
   logic [31:0] odata = 32'h0;
   logic        pre_we = 1'b0;
   logic [13:0] pre_addr = 14'h0;
   logic [31:0] pre_data = 32'h0;

   always @(posedge clk) begin
      if (pre_we)
         mem[pre_addr] <= pre_data;
      else if (bus.sram_wr_en)
         mem[bus.sram_addr[13:0]] <= bus.sram_idata;
      if (bus.sram_rd_en)
         odata <= mem[bus.sram_addr[13:0]];
   end

   assign bus.sram_odata = odata;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic preload(input logic [13:0] a, input logic [31:0] d);
      pre_addr = a;
      pre_data = d;
      pre_we   = 1'b1;
      cyc();
      pre_we   = 1'b0;
   endtask

   task automatic idle_inputs();
      bus.i_req   = 1'b0;
      bus.i_addr  = 16'h0;
      bus.d_req   = 1'b0;
      bus.d_we    = 1'b0;
      bus.d_be    = 4'h0;
      bus.d_addr  = 16'h0;
      bus.d_wdata = 32'h0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic exp_d;
      idle_inputs();
      #2 rst = 1'b0;

      preload(14'h0010, 32'hE3A00001);
      preload(14'h0020, 32'h12345678);
      preload(14'h0030, 32'h9ABCDEF0);
      preload(14'h0200, 32'h11223344);
      preload(14'h0300, 32'hCAFEF00D);
      preload(14'h0400, 32'h55667788);

      // Reset values, with both requests raised to show grants are forced off
      bus.i_req = 1'b1; bus.i_addr = 16'h0010;
      bus.d_req = 1'b1; bus.d_addr = 16'h0030;
      #1;
      check("rst_igat", 32'(bus.i_gnt), 32'd0);
      check("rst_dgnt", 32'(bus.d_gnt), 32'd0);
      check("rst_rden", 32'(bus.sram_rd_en), 32'd0);
      check("rst_wren", 32'(bus.sram_wr_en), 32'd0);
      check("rst_addr", 32'(bus.sram_addr), 32'd0);
      check("rst_idata", bus.sram_idata, 32'd0);
      check("rst_irv", 32'(bus.i_rvalid), 32'd0);
      check("rst_drv", 32'(bus.d_rvalid), 32'd0);
      idle_inputs();
      cyc();
      rst = 1'b1;
      cyc();

      // Single instruction fetch
      bus.i_req = 1'b1; bus.i_addr = 16'h0010;
      #1;
      check("if_gnt", 32'(bus.i_gnt), 32'd1);
      check("if_dgnt", 32'(bus.d_gnt), 32'd0);
      check("if_rden", 32'(bus.sram_rd_en), 32'd1);
      check("if_addr", 32'(bus.sram_addr), 32'h0010);
      cyc();
      bus.i_req = 1'b0;
      #1;
      check("if_rv", 32'(bus.i_rvalid), 32'd1);
      check("if_rdata", bus.i_rdata, 32'hE3A00001);
      check("if_dgnt2", 32'(bus.d_gnt), 32'd0);
      check("if_drv", 32'(bus.d_rvalid), 32'd0);
      cyc();
      check("if_rv_end", 32'(bus.i_rvalid), 32'd0);

      // Round-robin from a fresh reset: D, I, D, I
      rst = 1'b0;
      cyc();
      rst = 1'b1;
      bus.i_req = 1'b1; bus.i_addr = 16'h0020;
      bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 16'h0030;
      #1;
      for (int k = 0; k < 4; k++) begin
         exp_d = (k % 2 == 0);
         check("rr_dgnt", 32'(bus.d_gnt), 32'(exp_d));
         check("rr_igat", 32'(bus.i_gnt), 32'(!exp_d));
         if (k > 0) begin
            check("rr_irv", 32'(bus.i_rvalid), 32'(exp_d));
            check("rr_drv", 32'(bus.d_rvalid), 32'(!exp_d));
            check("rr_data", bus.d_rdata, exp_d ? 32'h12345678 : 32'h9ABCDEF0);
         end
         cyc();
      end
      idle_inputs();
      #1;
      check("rr_irv_last", 32'(bus.i_rvalid), 32'd1);
      check("rr_idata_last", bus.i_rdata, 32'h12345678);
      cyc();

      // Full write then immediate read of the same word
      bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_be = 4'hF;
      bus.d_addr = 16'h0100; bus.d_wdata = 32'hDEADBEEF;
      #1;
      check("fw_gnt", 32'(bus.d_gnt), 32'd1);
      check("fw_wren", 32'(bus.sram_wr_en), 32'd1);
      check("fw_rden", 32'(bus.sram_rd_en), 32'd0);
      check("fw_idata", bus.sram_idata, 32'hDEADBEEF);
      cyc();
      bus.d_we = 1'b0;
      #1;
      check("fw_rd_gnt", 32'(bus.d_gnt), 32'd1);
      check("fw_no_rv", 32'(bus.d_rvalid), 32'd0);
      cyc();
      idle_inputs();
      #1;
      check("fw_rv", 32'(bus.d_rvalid), 32'd1);
      check("fw_rdata", bus.d_rdata, 32'hDEADBEEF);

      // Instruction grant so the data port wins the coming tie
      bus.i_req = 1'b1; bus.i_addr = 16'h0010;
      #1;
      check("pw_pre_igat", 32'(bus.i_gnt), 32'd1);
      cyc();

      // Partial write with a concurrent instruction request
      bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_be = 4'b0101;
      bus.d_addr = 16'h0200; bus.d_wdata = 32'hAABBCCDD;
      #1;
      check("pw_n_rden", 32'(bus.sram_rd_en), 32'd1);
      check("pw_n_wren", 32'(bus.sram_wr_en), 32'd0);
      check("pw_n_addr", 32'(bus.sram_addr), 32'h0200);
      check("pw_n_dgnt", 32'(bus.d_gnt), 32'd0);
      check("pw_n_igat", 32'(bus.i_gnt), 32'd0);
      cyc();
      check("pw_n1_wren", 32'(bus.sram_wr_en), 32'd1);
      check("pw_n1_rden", 32'(bus.sram_rd_en), 32'd0);
      check("pw_n1_idata", bus.sram_idata, 32'h11BB33DD);
      check("pw_n1_addr", 32'(bus.sram_addr), 32'h0200);
      check("pw_n1_dgnt", 32'(bus.d_gnt), 32'd1);
      check("pw_n1_igat", 32'(bus.i_gnt), 32'd0);
      cyc();
      bus.d_req = 1'b0;
      #1;
      check("pw_n2_igat", 32'(bus.i_gnt), 32'd1);
      check("pw_n2_drv", 32'(bus.d_rvalid), 32'd0);
      cyc();
      idle_inputs();
      bus.d_req = 1'b1; bus.d_addr = 16'h0200;
      #1;
      check("pw_rb_gnt", 32'(bus.d_gnt), 32'd1);
      cyc();
      idle_inputs();
      #1;
      check("pw_rb_rv", 32'(bus.d_rvalid), 32'd1);
      check("pw_rb_data", bus.d_rdata, 32'h11BB33DD);

      // Write with no byte enables
      bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_be = 4'h0;
      bus.d_addr = 16'h0300; bus.d_wdata = 32'hFFFFFFFF;
      #1;
      check("be0_gnt", 32'(bus.d_gnt), 32'd1);
      check("be0_wren", 32'(bus.sram_wr_en), 32'd0);
      check("be0_rden", 32'(bus.sram_rd_en), 32'd0);
      cyc();
      idle_inputs();
      #1;
      check("be0_drv", 32'(bus.d_rvalid), 32'd0);
      check("be0_mem", mem[14'h0300], 32'hCAFEF00D);

      // Reset asserted during the write half of a partial write
      bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_be = 4'b0011;
      bus.d_addr = 16'h0400; bus.d_wdata = 32'h00000000;
      #1;
      check("ra_n_rden", 32'(bus.sram_rd_en), 32'd1);
      cyc();
      check("ra_n1_wren", 32'(bus.sram_wr_en), 32'd1);
      rst = 1'b0;
      #1;
      check("ra_wren", 32'(bus.sram_wr_en), 32'd0);
      check("ra_dgnt", 32'(bus.d_gnt), 32'd0);
      check("ra_rden", 32'(bus.sram_rd_en), 32'd0);
      check("ra_addr", 32'(bus.sram_addr), 32'd0);
      check("ra_idata", bus.sram_idata, 32'd0);
      idle_inputs();
      cyc();
      rst = 1'b1;
      cyc();
      check("ra_mem", mem[14'h0400], 32'h55667788);
      bus.d_req = 1'b1; bus.d_addr = 16'h0400;
      #1;
      check("ra_rb_gnt", 32'(bus.d_gnt), 32'd1);
      cyc();
      idle_inputs();
      #1;
      check("ra_rb_data", bus.d_rdata, 32'h55667788);
      cyc();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Two-requester arbiter and sequencer in front of the single-port 32-bit word SRAM (16384 words, 1-cycle registered read). It shares the SRAM between the CPU instruction-fetch port (read-only) and the data port (read/write with byte enables). It also turns partial-word writes into a read-modify-write pair. It sits between the core's fetch/load-store units and the `sram` instance, and drives that instance's `rd_en`/`wr_en`/`addr`/`idata` while consuming its `odata`.

## Interface
- No parameters. Widths are fixed by the SRAM: 16-bit word address, 32-bit data.
- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- i_req  in  1  instruction read request, held with i_addr until granted
- i_addr  in  16  instruction word address
- i_gnt  out  1  request accepted this cycle (combinational)
- i_rvalid  out  1  i_rdata valid (registered)
- i_rdata  out  32  read data, = sram_odata
- d_req  in  1  data request, held with d_we/d_be/d_addr/d_wdata until granted
- d_we  in  1  1 = write, 0 = read
- d_be  in  4  byte enables for writes; bit k selects bits [8k+7:8k]
- d_addr  in  16  data word address
- d_wdata  in  32  write data
- d_gnt  out  1  request accepted/completed this cycle (combinational)
- d_rvalid  out  1  d_rdata valid (registered)
- d_rdata  out  32  read data, = sram_odata
- sram_rd_en  out  1  to SRAM rd_en
- sram_wr_en  out  1  to SRAM wr_en
- sram_addr  out  16  to SRAM addr
- sram_idata  out  32  to SRAM idata
- sram_odata  in  32  from SRAM odata

## Operation
- FSM states: IDLE, RMW_WR. At most one SRAM access per cycle. sram_rd_en and sram_wr_en are never both 1.
- IDLE, arbitration:
  - Only one req high: that port wins.
  - Both high: the port not granted last wins (round-robin).
  - `last` pointer updates on every grant.
- Instruction win: sram_rd_en=1, sram_addr=i_addr, i_gnt=1. i_rvalid=1 next cycle.
- Data read win: sram_rd_en=1, sram_addr=d_addr, d_gnt=1. d_rvalid=1 next cycle.
- Data write, d_be=4'hF: sram_wr_en=1, sram_addr=d_addr, sram_idata=d_wdata, d_gnt=1. No rvalid.
- Data write, d_be=4'h0: d_gnt=1. No SRAM access, no rvalid.
- Data write, partial d_be:
  - IDLE cycle: sram_rd_en=1 at d_addr, d_gnt=0. Latch addr/be/wdata, go to RMW_WR, set `last` = data.
  - RMW_WR cycle: sram_wr_en=1, sram_idata = per-byte mux (d_be[k] ? d_wdata byte : sram_odata byte), d_gnt=1, return to IDLE.
  - i_req is not granted in RMW_WR. No d_rvalid is generated.
- Idle outputs: sram_rd_en=0, sram_wr_en=0, sram_addr=0, sram_idata=0.
- Addresses pass through unchanged. Requesters keep them within 0..16383.
- i_rdata and d_rdata are wired from sram_odata. Their value is meaningful only while the matching rvalid is 1.

## Timing
- Read latency: grant at edge N, rvalid high for exactly cycle N+1. Throughput is 1 access/cycle, so back-to-back grants are allowed.
- Full write: 1 cycle. Partial write: 2 cycles, d_gnt in the second.
- Write at cycle N followed by a read of the same address at N+1 returns the new data.
- A requester may assert a new req in the same cycle its rvalid is high. The bench accepts the response unconditionally; there is no backpressure.
- Reset (rst low, any time): state=IDLE, `last`=instruction (the data port wins the first tie). i_gnt, d_gnt, i_rvalid, d_rvalid, sram_rd_en, sram_wr_en are all 0; sram_addr=0, sram_idata=0.
  - Grants are forced to 0 while rst is low.
  - Reset during RMW_WR aborts: no write issued, no d_gnt.
- req deasserted before grant is legal (request withdrawn). Exception: a partial-write request must stay asserted until d_gnt.

## Test plan
- Reset release, then only i_req, i_addr=0x0010 (mem=0xE3A00001): i_gnt at N, i_rvalid at N+1 with i_rdata=0xE3A00001; d_gnt=0 throughout.
- i_req and d_req (read) both held 4 cycles from reset: grants alternate D, I, D, I. Each rvalid arrives one cycle after its grant with the correct data.
- Data full write 0xDEADBEEF to 0x0100, then data read 0x0100 next cycle: d_gnt at N, read d_gnt at N+1, d_rvalid at N+2 with 0xDEADBEEF.
- Partial write: mem[0x0200]=0x11223344, d_be=4'b0101, d_wdata=0xAABBCCDD. Required: rd at N, wr at N+1 with sram_idata=0x11BB33DD, d_gnt only at N+1. A concurrent i_req is granted no earlier than N+2. A readback gives 0x11BB33DD.
- d_be=0 write to 0x0300 holding 0xCAFEF00D: d_gnt in one cycle, sram_wr_en never 1, memory unchanged.
- rst pulled low in the RMW_WR cycle: sram_wr_en=0, d_gnt=0, all outputs at reset values. Target word is unchanged after reset release.
